bus_io_port: RTL and testbench
==============================

// Module: bus_io_port
// PURPOSE
//  Peripheral-side peer for the processor's byte I/O handshake (bus_in/bus_out/hs_in/hs_out).
//  Each 4-phase transaction is an exchange:
//  - the byte on the processor's bus_out is pushed into a TX FIFO for the host;
//  - the head of an RX FIFO, filled by the host, is presented on the processor's bus_in.
//  Decouples processor I/O from the host/testbench; sits directly outside the processor top level.
// PARAMETERS
//  DEPTH       4      entries per FIFO; power of 2, >=2
//  AW          2      log2(DEPTH); count outputs are AW+1 bits
//  EMPTY_BYTE  8'h00  value driven on p_bus_in when the RX FIFO is empty at exchange
// PORTS
//  g_clk        in   1     clock; all state updates on rising edge
//  g_clr        in   1     reset, synchronous, active-high
//  p_hs_out     in   1     REQ from processor hs_out
//  p_bus_out    in   8     processor bus_out; valid while p_hs_out=1
//  p_hs_in      out  1     ACK to processor hs_in
//  p_bus_in     out  8     byte to processor bus_in, registered
//  rx_wr_en     in   1     host push into RX FIFO
//  rx_wr_data   in   8     host byte for RX FIFO
//  rx_full      out  1     RX FIFO full
//  rx_count     out  AW+1  RX occupancy
//  tx_rd_en     in   1     host pop from TX FIFO
//  tx_rd_data   out  8     TX FIFO head, first-word-fall-through; 0 when empty
//  tx_empty     out  1     TX FIFO empty
//  tx_count     out  AW+1  TX occupancy
//  err_clr      in   1     clears sticky error flags
//  err_ovf      out  1     sticky: host wrote while rx_full
//  err_unf      out  1     sticky: exchange occurred with RX FIFO empty
// BEHAVIOUR
//  Reset (g_clr=1 at edge) forces:
//  - p_hs_in=0, p_bus_in=0; both FIFOs empty, pointers 0, counts 0;
//  - rx_full=0, tx_empty=1, err flags 0, FSM->IDLE.
//  Reset mid-handshake is legal: ACK drops on that same edge and the exchange is abandoned.
//  FSM, one-hot or binary: IDLE, ACK, WAIT_REL.
//  - IDLE: if p_hs_out=1 and TX not full:
//    - push p_bus_out to TX;
//    - load p_bus_in with RX head and pop it; if RX empty, load EMPTY_BYTE and set err_unf;
//    - p_hs_in<=1; go ACK.
//    If TX is full, stay in IDLE; REQ is held off with no data loss.
//  - ACK: hold p_hs_in=1 and p_bus_in stable until p_hs_out=0, then p_hs_in<=0 and go WAIT_REL.
//  - WAIT_REL: one cycle with p_hs_in=0, then IDLE. A REQ still high here is not sampled,
//    so a new exchange needs at least one idle cycle.
//  Latency: REQ sampled high at edge k -> p_hs_in=1 and p_bus_in valid after edge k (same edge).
//  Exactly one TX push and at most one RX pop per handshake, regardless of REQ width.
//  Host RX write:
//  - accepted iff !rx_full before the edge;
//  - if full, the write is dropped and err_ovf is set;
//  - a simultaneous exchange pop never frees space for that write.
//  Host TX read: pops iff !tx_empty; ignored otherwise; no error.
//  Simultaneous host RX write with exchange pop:
//  - pop takes the old head;
//  - if RX was empty, the write lands, no pop occurs, and the exchange takes EMPTY_BYTE.
//  Simultaneous host TX pop with exchange push: both occur; count unchanged when nonempty.
//  Pointers wrap modulo DEPTH. Counts are exact, 0..DEPTH.
//  full  = (count==DEPTH); empty = (count==0).
//  err_clr clears flags at the edge; a same-cycle set event wins over err_clr.
// TESTING
//  1. Reset with FIFOs nonempty and p_hs_in=1 -> next cycle p_hs_in=0, counts 0,
//     tx_empty=1, p_bus_in=0.
//  2. Host writes 8'hA5, 8'h3C; processor REQ with bus_out=8'h11, held 3 cycles ->
//     - p_bus_in=8'hA5 with ACK one cycle after REQ;
//     - tx_rd_data=8'h11, rx_count=1;
//     - ACK drops one edge after REQ drops.
//  3. Exchange with RX empty -> p_bus_in=8'h00, err_unf=1; err_clr -> err_unf=0 next cycle.
//  4. Four exchanges with no host reads (DEPTH=4), then a fifth REQ ->
//     - no ACK while tx_count=4;
//     - one tx_rd_en -> ACK next cycle, 5th byte is queued.
//  5. Five host writes into an empty RX FIFO -> rx_full=1 after 4, err_ovf=1, 5th byte absent.
//  6. Wrap: 10 exchanges interleaved with host reads/writes ->
//     TX byte order equals bus_out order, RX order equals write order.

Source files
------------

// File: rtl/bus_io_port.sv
// bus_io_port: peripheral-side peer for the processor's 4-phase byte I/O handshake.
// Each handshake pushes bus_out into a TX FIFO and returns the RX FIFO head on bus_in.
module bus_io_port #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned AW         = 2,
    parameter logic [7:0]  EMPTY_BYTE = 8'h00
) (
    input  logic          g_clk,
    input  logic          g_clr,
    input  logic          p_hs_out,
    input  logic [7:0]    p_bus_out,
    output logic          p_hs_in,
    output logic [7:0]    p_bus_in,
    input  logic          rx_wr_en,
    input  logic [7:0]    rx_wr_data,
    output logic          rx_full,
    output logic [AW:0]   rx_count,
    input  logic          tx_rd_en,
    output logic [7:0]    tx_rd_data,
    output logic          tx_empty,
    output logic [AW:0]   tx_count,
    input  logic          err_clr,
    output logic          err_ovf,
    output logic          err_unf
);

    localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StAck, StWaitRel} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_hs_in, w_hs_in_nxt;
    logic [7:0]    r_bus_in, w_bus_in_nxt;
    logic          r_err_ovf, r_err_unf;

    logic [7:0]    r_rx_mem [DEPTH];
    logic [AW-1:0] r_rx_wptr, r_rx_rptr;
    logic [AW:0]   r_rx_count;
    logic [7:0]    r_tx_mem [DEPTH];
    logic [AW-1:0] r_tx_wptr, r_tx_rptr;
    logic [AW:0]   r_tx_count;

    logic w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
    logic w_xchg, w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;

    assign w_rx_full  = (r_rx_count == FullCnt);
    assign w_rx_empty = (r_rx_count == '0);
    assign w_tx_full  = (r_tx_count == FullCnt);
    assign w_tx_empty = (r_tx_count == '0);

    // Host write only sees pre-edge occupancy, so a same-edge exchange pop never makes room.
    assign w_rx_push = rx_wr_en && !w_rx_full;
    assign w_rx_pop  = w_xchg && !w_rx_empty;
    assign w_tx_push = w_xchg;
    assign w_tx_pop  = tx_rd_en && !w_tx_empty;

    always_comb begin
        w_state_nxt  = r_state;
        w_hs_in_nxt  = r_hs_in;
        w_bus_in_nxt = r_bus_in;
        w_xchg       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (p_hs_out && !w_tx_full) begin
                    w_xchg       = 1'b1;
                    w_hs_in_nxt  = 1'b1;
                    w_bus_in_nxt = w_rx_empty ? EMPTY_BYTE : r_rx_mem[r_rx_rptr];
                    w_state_nxt  = StAck;
                end
            end
            StAck: begin
                if (!p_hs_out) begin
                    w_hs_in_nxt = 1'b0;
                    w_state_nxt = StWaitRel;
                end
            end
            StWaitRel: w_state_nxt = StIdle;
            default:   w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            r_state   <= StIdle;
            r_hs_in   <= 1'b0;
            r_bus_in  <= 8'h00;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hs_in   <= w_hs_in_nxt;
            r_bus_in  <= w_bus_in_nxt;
            r_err_ovf <= (rx_wr_en && w_rx_full) || (r_err_ovf && !err_clr);
            r_err_unf <= (w_xchg && w_rx_empty) || (r_err_unf && !err_clr);
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + 1'b1;
                2'b01:   r_rx_count <= r_rx_count - 1'b1;
                default: ;
            endcase
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + 1'b1;
                2'b01:   r_tx_count <= r_tx_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is not reset; occupancy counts gate every read.
    always_ff @(posedge g_clk) begin
        if (!g_clr && w_rx_push) r_rx_mem[r_rx_wptr] <= rx_wr_data;
        if (!g_clr && w_tx_push) r_tx_mem[r_tx_wptr] <= p_bus_out;
    end

    assign p_hs_in    = r_hs_in;
    assign p_bus_in   = r_bus_in;
    assign rx_full    = w_rx_full;
    assign rx_count   = r_rx_count;
    assign tx_empty   = w_tx_empty;
    assign tx_count   = r_tx_count;
    assign tx_rd_data = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rptr];
    assign err_ovf    = r_err_ovf;
    assign err_unf    = r_err_unf;

endmodule

// File: tb/tb_bus_io_port.sv
// tb_bus_io_port: table vectors, hand-written handshake corner cases and a randomized
// run checked against a queue-based model of the two FIFOs and the sticky flags.
module tb_bus_io_port;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic          g_clk = 1'b0;
    logic          g_clr, p_hs_out, rx_wr_en, tx_rd_en, err_clr;
    logic [7:0]    p_bus_out, rx_wr_data;
    logic          p_hs_in, rx_full, tx_empty, err_ovf, err_unf;
    logic [7:0]    p_bus_in, tx_rd_data;
    logic [AW:0]   rx_count, tx_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic       m_ovf, m_unf;

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       clr;
        logic [2:0] cnt;
        logic       full;
        logic       ovf;
    } vec_t;
    vec_t vecs [0:5];

    bus_io_port #(.DEPTH(DEPTH), .AW(AW), .EMPTY_BYTE(8'h00)) dut (
        .g_clk      (g_clk),
        .g_clr      (g_clr),
        .p_hs_out   (p_hs_out),
        .p_bus_out  (p_bus_out),
        .p_hs_in    (p_hs_in),
        .p_bus_in   (p_bus_in),
        .rx_wr_en   (rx_wr_en),
        .rx_wr_data (rx_wr_data),
        .rx_full    (rx_full),
        .rx_count   (rx_count),
        .tx_rd_en   (tx_rd_en),
        .tx_rd_data (tx_rd_data),
        .tx_empty   (tx_empty),
        .tx_count   (tx_count),
        .err_clr    (err_clr),
        .err_ovf    (err_ovf),
        .err_unf    (err_unf)
    );

    always #5 g_clk = ~g_clk;

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        g_clr = 1'b1;
        tick();
        g_clr = 1'b0;
        rx_q.delete();
        tx_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic host_write(input logic [7:0] b);
        rx_wr_en = 1'b1;
        rx_wr_data = b;
        tick();
        rx_wr_en = 1'b0;
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
        else m_ovf = 1'b1;
        chk("wr_rx_count", 32'(rx_count), 32'(rx_q.size()));
        chk("wr_rx_full", 32'(rx_full), 32'(rx_q.size() == DEPTH));
        chk("wr_err_ovf", 32'(err_ovf), 32'(m_ovf));
    endtask

    task automatic host_read();
        logic [7:0] exp_b;
        exp_b = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
        chk("rd_data", 32'(tx_rd_data), 32'(exp_b));
        chk("rd_empty", 32'(tx_empty), 32'(tx_q.size() == 0));
        tx_rd_en = 1'b1;
        tick();
        tx_rd_en = 1'b0;
        if (tx_q.size() != 0) void'(tx_q.pop_front());
        chk("rd_tx_count", 32'(tx_count), 32'(tx_q.size()));
    endtask

    // Full processor-side handshake; assumes TX has room.
    task automatic exchange(input logic [7:0] b, input int hold);
        logic [7:0] exp_b;
        int n;
        p_hs_out = 1'b1;
        p_bus_out = b;
        tick();
        n = 0;
        while (!p_hs_in && n < 8) begin
            tick();
            n++;
        end
        if (rx_q.size() != 0) exp_b = rx_q.pop_front();
        else begin
            exp_b = 8'h00;
            m_unf = 1'b1;
        end
        tx_q.push_back(b);
        chk("xchg_ack", 32'(p_hs_in), 32'(1));
        chk("xchg_latency", 32'(n), 32'(0));
        chk("xchg_bus_in", 32'(p_bus_in), 32'(exp_b));
        chk("xchg_err_unf", 32'(err_unf), 32'(m_unf));
        for (int i = 1; i < hold; i++) begin
            tick();
            chk("hold_ack", 32'(p_hs_in), 32'(1));
            chk("hold_bus_in", 32'(p_bus_in), 32'(exp_b));
        end
        p_hs_out = 1'b0;
        p_bus_out = 8'($urandom);
        tick();
        chk("rel_ack", 32'(p_hs_in), 32'(0));
        tick();
        chk("xchg_tx_count", 32'(tx_count), 32'(tx_q.size()));
        chk("xchg_rx_count", 32'(rx_count), 32'(rx_q.size()));
    endtask

    initial begin
        g_clr = 1'b1; p_hs_out = 1'b0; p_bus_out = 8'h00; rx_wr_en = 1'b0;
        rx_wr_data = 8'h00; tx_rd_en = 1'b0; err_clr = 1'b0;
        tick();
        do_reset();
        chk("reset_hs_in", 32'(p_hs_in), 32'(0));
        chk("reset_tx_empty", 32'(tx_empty), 32'(1));

        // 1: reset with both FIFOs occupied and ACK high.
        host_write(8'h12);
        host_write(8'h34);
        p_hs_out = 1'b1; p_bus_out = 8'h56;
        tick();
        chk("pre_reset_ack", 32'(p_hs_in), 32'(1));
        g_clr = 1'b1;
        tick();
        chk("mid_reset_hs_in", 32'(p_hs_in), 32'(0));
        chk("mid_reset_bus_in", 32'(p_bus_in), 32'(0));
        chk("mid_reset_rx_count", 32'(rx_count), 32'(0));
        chk("mid_reset_tx_count", 32'(tx_count), 32'(0));
        chk("mid_reset_tx_empty", 32'(tx_empty), 32'(1));
        chk("mid_reset_rx_full", 32'(rx_full), 32'(0));
        chk("mid_reset_unf", 32'(err_unf), 32'(0));
        g_clr = 1'b0; p_hs_out = 1'b0;
        do_reset();

        // 2: basic exchange with REQ held 3 cycles.
        host_write(8'hA5);
        host_write(8'h3C);
        exchange(8'h11, 3);
        chk("t2_tx_head", 32'(tx_rd_data), 32'(8'h11));

        // 3: underflow, then err_clr; a same-cycle set beats the clear.
        exchange(8'h22, 1);
        exchange(8'h33, 1);
        chk("t3_unf", 32'(err_unf), 32'(1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_unf = 1'b0;
        chk("t3_unf_clr", 32'(err_unf), 32'(0));
        err_clr = 1'b1; p_hs_out = 1'b1; p_bus_out = 8'h44;
        tick();
        err_clr = 1'b0; p_hs_out = 1'b0;
        chk("t3_set_wins", 32'(err_unf), 32'(1));
        tick(); tick();

        // 4: TX full holds REQ off until the host pops.
        do_reset();
        for (int i = 0; i < 4; i++) exchange(8'hE0 + 8'(i), 1);
        p_hs_out = 1'b1; p_bus_out = 8'hE4;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_no_ack", 32'(p_hs_in), 32'(0));
            chk("t4_tx_full", 32'(tx_count), 32'(4));
        end
        tx_rd_en = 1'b1;
        tick();
        tx_rd_en = 1'b0;
        chk("t4_ack_after_pop_edge", 32'(p_hs_in), 32'(0));
        chk("t4_count_after_pop", 32'(tx_count), 32'(3));
        tick();
        chk("t4_ack", 32'(p_hs_in), 32'(1));
        chk("t4_count_refill", 32'(tx_count), 32'(4));
        p_hs_out = 1'b0;
        tick(); tick();
        void'(tx_q.pop_front());
        tx_q.push_back(8'hE4);
        for (int i = 0; i < 4; i++) host_read();

        // 5: table-driven RX fill and overflow.
        do_reset();
        vecs[0] = '{1'b1, 8'hC0, 1'b0, 3'd1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'hC1, 1'b0, 3'd2, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'hC2, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'hC3, 1'b0, 3'd4, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'hC4, 1'b0, 3'd4, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            rx_wr_en = vecs[i].wr; rx_wr_data = vecs[i].data; err_clr = vecs[i].clr;
            tick();
            rx_wr_en = 1'b0; err_clr = 1'b0;
            chk($sformatf("vec%0d_count", i), 32'(rx_count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_full", i), 32'(rx_full), 32'(vecs[i].full));
            chk($sformatf("vec%0d_ovf", i), 32'(err_ovf), 32'(vecs[i].ovf));
        end
        rx_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        for (int i = 0; i < 5; i++) begin
            exchange(8'h70 + 8'(i), 1);
            host_read();
        end

        // Simultaneous host traffic and exchange.
        do_reset();
        p_hs_out = 1'b1; p_bus_out = 8'h55; rx_wr_en = 1'b1; rx_wr_data = 8'h77;
        tick();
        chk("sim_empty_bus_in", 32'(p_bus_in), 32'(8'h00));
        chk("sim_empty_unf", 32'(err_unf), 32'(1));
        chk("sim_empty_rx_count", 32'(rx_count), 32'(1));
        p_hs_out = 1'b0; rx_wr_en = 1'b0;
        tick(); tick();
        p_hs_out = 1'b1; p_bus_out = 8'h66; rx_wr_en = 1'b1; rx_wr_data = 8'h88;
        tick();
        chk("sim_pop_old_head", 32'(p_bus_in), 32'(8'h77));
        chk("sim_pop_rx_count", 32'(rx_count), 32'(1));
        p_hs_out = 1'b0; rx_wr_en = 1'b0;
        tick(); tick();
        p_hs_out = 1'b1; p_bus_out = 8'h99; tx_rd_en = 1'b1;
        tick();
        chk("sim_new_head", 32'(p_bus_in), 32'(8'h88));
        chk("sim_tx_count_same", 32'(tx_count), 32'(2));
        chk("sim_tx_head", 32'(tx_rd_data), 32'(8'h66));
        p_hs_out = 1'b0; tx_rd_en = 1'b0;
        tick(); tick();

        // 6: randomized interleaving against the queue model (exercises pointer wrap).
        do_reset();
        for (int i = 0; i < 300; i++) begin
            int unsigned op;
            op = $urandom_range(0, 9);
            if (op <= 3) host_write(8'($urandom));
            else if (op <= 6 || tx_q.size() == DEPTH) host_read();
            else if (op <= 8) exchange(8'($urandom), int'($urandom_range(1, 3)));
            else begin
                err_clr = 1'b1;
                tick();
                err_clr = 1'b0;
                m_ovf = 1'b0;
                m_unf = 1'b0;
                chk("rnd_clr_ovf", 32'(err_ovf), 32'(0));
                chk("rnd_clr_unf", 32'(err_unf), 32'(0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
